// File: rtl/alu_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// Bus interfaces for alu_rr_scheduler.
//
// alu_rr_req_if : requester side (request bundle in, response bundle out)
//   req_vld  [NUM_REQ]       per-requester request valid
//   req_rdy  [NUM_REQ]       one-hot accept pulse
//   req_op   [NUM_REQ*4]     opcode, slice i belongs to requester i
//   req_movi [NUM_REQ*2]     operand-B source select
//   req_a/b  [NUM_REQ*DW]    operands
//   rsp_vld/rsp_rdy          response handshake
//   rsp_id   [IDW]           requester ID of the response
//   rsp_data [DW]            result
//   rsp_err                  timeout error flag
//   modport master = requester agents, modport slave = scheduler
//
// alu_rr_alu_if : ALU side
//   alu_act, alu_op, alu_movi, alu_reg_a, alu_reg_b, alu_mem, alu_imm
//   alu_rdy, ex_alu, ex_alu_vld
//   modport master = scheduler, modport slave = ALU
// ---------------------------------------------------------------------------
interface alu_rr_req_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_vld;
  logic [NUM_REQ-1:0]            req_rdy;
  logic [NUM_REQ*4-1:0]          req_op;
  logic [NUM_REQ*2-1:0]          req_movi;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic                          rsp_vld;
  logic                          rsp_rdy;
  logic [IDW-1:0]                rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_err;

  modport master (
    output req_vld, req_op, req_movi, req_a, req_b, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_vld, req_op, req_movi, req_a, req_b, rsp_rdy,
    output req_rdy, rsp_vld, rsp_id, rsp_data, rsp_err
  );
endinterface

interface alu_rr_alu_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  alu_act;
  logic [3:0]            alu_op;
  logic [1:0]            alu_movi;
  logic [DATA_WIDTH-1:0] alu_reg_a;
  logic [DATA_WIDTH-1:0] alu_reg_b;
  logic [DATA_WIDTH-1:0] alu_mem;
  logic [DATA_WIDTH-1:0] alu_imm;
  logic                  alu_rdy;
  logic [DATA_WIDTH-1:0] ex_alu;
  logic                  ex_alu_vld;

  modport master (
    output alu_act, alu_op, alu_movi, alu_reg_a, alu_reg_b, alu_mem, alu_imm,
    input  alu_rdy, ex_alu, ex_alu_vld
  );

  modport slave (
    input  alu_act, alu_op, alu_movi, alu_reg_a, alu_reg_b, alu_mem, alu_imm,
    output alu_rdy, ex_alu, ex_alu_vld
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
// Shares one ALU between NUM_REQ requesters. Requests are granted round-robin,
// one operation is in flight at a time, and each result is returned with the
// ID of the requester that issued it.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset
//   req_bus  alu_rr_req_if.slave  : requests in, responses out
//   alu_bus  alu_rr_alu_if.master : operation out, result in
//
// Optional feature macro: ALU_TIMEOUT_EN
//   defined   : WAIT_RES gives up after TIMEOUT_CYCLES cycles and responds with
//               rsp_err=1, rsp_data=0
//   undefined : WAIT_RES waits indefinitely, rsp_err is tied to 0
// ---------------------------------------------------------------------------
module alu_rr_scheduler #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  alu_rr_req_if.slave  req_bus,
  alu_rr_alu_if.master alu_bus
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RES = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // per-requester slices of the flat request buses
  logic [3:0]            w_op   [NUM_REQ];
  logic [1:0]            w_movi [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_a    [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_b    [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign w_op[gi]   = req_bus.req_op[gi*4 +: 4];
    assign w_movi[gi] = req_bus.req_movi[gi*2 +: 2];
    assign w_a[gi]    = req_bus.req_a[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_b[gi]    = req_bus.req_b[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // latched operation and response state
  logic [IDW-1:0]        r_last;
  logic [IDW-1:0]        r_id;
  logic [3:0]            r_op;
  logic [1:0]            r_movi;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_rsp_data;

  // -------------------------------------------------------------------------
  // Round-robin search: scan LAST+1, LAST+2, ... and keep the first valid.
  // The loop walks from the far end back so the nearest hit is written last.
  // -------------------------------------------------------------------------
  logic           w_any_vld;
  logic [IDW-1:0] w_grant_id;
  int             w_idx;

  always_comb begin
    w_any_vld  = 1'b0;
    w_grant_id = '0;
    w_idx      = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = (int'(r_last) + k) % NUM_REQ;
      if (req_bus.req_vld[IDW'(w_idx)]) begin
        w_any_vld  = 1'b1;
        w_grant_id = IDW'(w_idx);
      end
    end
  end

  // reset is gated in so nothing is accepted while reset is held
  logic w_grant;
  assign w_grant = (r_state == ST_IDLE) && alu_bus.alu_rdy && w_any_vld && !i_rst;

  // -------------------------------------------------------------------------
  // Optional WAIT_RES timeout
  // -------------------------------------------------------------------------
  logic w_timeout;

`ifdef ALU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_rsp_err;

  // fires on the last of TIMEOUT_CYCLES WAIT_RES cycles without a result
  assign w_timeout = (r_state == ST_WAIT_RES) && !alu_bus.ex_alu_vld &&
                     (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmo_cnt <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state == ST_ISSUE) begin
        r_tmo_cnt <= '0;
      end else if (r_state == ST_WAIT_RES) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if (r_state == ST_WAIT_RES) begin
        if (alu_bus.ex_alu_vld) begin
          r_rsp_err <= 1'b0;
        end else if (w_timeout) begin
          r_rsp_err <= 1'b1;
        end
      end
    end
  end

  assign req_bus.rsp_err = r_rsp_err;
`else
  assign w_timeout       = 1'b0;
  assign req_bus.rsp_err = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_grant) w_state_next = ST_ISSUE;
      ST_ISSUE:    w_state_next = ST_WAIT_RES;
      // a result arriving during ISSUE is deliberately not looked at
      ST_WAIT_RES: if (alu_bus.ex_alu_vld || w_timeout) w_state_next = ST_RESP;
      ST_RESP:     if (req_bus.rsp_rdy) w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0] w_req_rdy;
  logic               w_alu_act;
  logic               w_rsp_vld;

  always_comb begin
    w_req_rdy = '0;
    w_alu_act = 1'b0;
    w_rsp_vld = 1'b0;
    if (w_grant) w_req_rdy[w_grant_id] = 1'b1;
    if (r_state == ST_ISSUE) w_alu_act = 1'b1;
    if (r_state == ST_RESP) w_rsp_vld = 1'b1;
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last     <= IDW'(NUM_REQ - 1);
      r_id       <= '0;
      r_op       <= '0;
      r_movi     <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_rsp_data <= '0;
    end else begin
      if (w_grant) begin
        r_id   <= w_grant_id;
        r_op   <= w_op[w_grant_id];
        // reserved select 11 is folded into REG_B
        r_movi <= (w_movi[w_grant_id] == 2'b11) ? 2'b00 : w_movi[w_grant_id];
        r_a    <= w_a[w_grant_id];
        r_b    <= w_b[w_grant_id];
      end
      if (r_state == ST_WAIT_RES) begin
        if (alu_bus.ex_alu_vld) begin
          r_rsp_data <= alu_bus.ex_alu;
        end else if (w_timeout) begin
          r_rsp_data <= '0;
        end
      end
      if ((r_state == ST_RESP) && req_bus.rsp_rdy) begin
        r_last <= r_id;
      end
    end
  end

  // operands are held from the registers, stable until the next grant
  assign req_bus.req_rdy  = w_req_rdy;
  assign req_bus.rsp_vld  = w_rsp_vld;
  assign req_bus.rsp_id   = r_id;
  assign req_bus.rsp_data = r_rsp_data;

  assign alu_bus.alu_act   = w_alu_act;
  assign alu_bus.alu_op    = r_op;
  assign alu_bus.alu_movi  = r_movi;
  assign alu_bus.alu_reg_a = r_a;
  assign alu_bus.alu_reg_b = (r_movi == 2'b00) ? r_b : '0;
  assign alu_bus.alu_mem   = (r_movi == 2'b01) ? r_b : '0;
  assign alu_bus.alu_imm   = (r_movi == 2'b10) ? r_b : '0;

endmodule
